// File: rtl/jitdom_switch_ctrl.sv
// rtl/jitdom_switch_ctrl.sv - JITDomain domain-change sequencer for commit port 0
//
// Purpose: stalls a chg_dom instruction at commit, drains the store buffer,
// writes curdom once, requests a pipeline flush and acknowledges the commit
// only after the flush completes. All outputs decode from registered state.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_valid_i, req_dom_i  chg_dom instruction valid / requested domain
//   cur_dom_i               current curdom CSR value
//   halt_i                  core halt request (aborts while draining)
//   no_st_pending_i         store buffer empty
//   flush_done_i            controller finished the flush
//   req_ack_o               one-cycle commit acknowledge
//   csr_write_dom_o, csr_wdata_o  curdom write strobe / zero-extended data
//   flush_req_o             flush request level
//   ex_valid_o, ex_cause_o  illegal-domain exception pulse / cause
//   busy_o                  sequence in progress
//   drain_timeout_o         sticky drain-timeout flag
module jitdom_switch_ctrl #(
    parameter int DomBits      = 2,
    parameter int NrDom        = 4,
    parameter int XLEN         = 64,
    parameter int DrainTimeout = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    input  logic [DomBits-1:0] req_dom_i,
    input  logic [DomBits-1:0] cur_dom_i,
    input  logic               halt_i,
    input  logic               no_st_pending_i,
    input  logic               flush_done_i,
    output logic               req_ack_o,
    output logic               csr_write_dom_o,
    output logic [XLEN-1:0]    csr_wdata_o,
    output logic               flush_req_o,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_cause_o,
    output logic               busy_o,
    output logic               drain_timeout_o
);

    localparam int                CntW   = $clog2(DrainTimeout + 1);
    localparam logic [CntW-1:0]   CntMax = CntW'(DrainTimeout);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRAIN = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_ACK   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [DomBits-1:0] dom_q, dom_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               ex_q, ex_d;
    // Set for the single IDLE cycle after ACK so the retiring instruction,
    // still presented on the commit port, is not accepted a second time.
    logic               hold_q, hold_d;

    logic req_legal;
    assign req_legal = int'(req_dom_i) < NrDom;

    always_comb begin
        state_d   = state_q;
        dom_d     = dom_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        ex_d      = 1'b0;
        hold_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hold_q && req_valid_i && !halt_i) begin
                    if (!req_legal) begin
                        ex_d = 1'b1;
                    end else if (req_dom_i == cur_dom_i) begin
                        state_d = S_ACK;
                    end else begin
                        dom_d   = req_dom_i;
                        cnt_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Abort outranks a drained store buffer.
                if (halt_i || !req_valid_i) begin
                    state_d = S_IDLE;
                end else if (no_st_pending_i) begin
                    state_d = S_WRITE;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                    if (cnt_d == CntMax) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            S_WRITE: state_d = S_FLUSH;
            S_FLUSH: begin
                if (flush_done_i) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                hold_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            dom_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            ex_q      <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dom_q     <= dom_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            ex_q      <= ex_d;
            hold_q    <= hold_d;
        end
    end

    assign req_ack_o       = (state_q == S_ACK);
    assign csr_write_dom_o = (state_q == S_WRITE);
    assign csr_wdata_o     = (state_q == S_WRITE) ? {{(XLEN-DomBits){1'b0}}, dom_q} : '0;
    assign flush_req_o     = (state_q == S_FLUSH);
    assign ex_valid_o      = ex_q;
    assign ex_cause_o      = ex_q ? XLEN'(2) : '0;
    assign busy_o          = (state_q != S_IDLE);
    assign drain_timeout_o = timeout_q;

endmodule

// File: doc/jitdom_switch_ctrl.md
Name: jitdom_switch_ctrl

Overview:
- Sequences a JITDomain domain change for an instruction sitting at commit port 0 with chg_dom set.
- Stalls that instruction's commit and drains the store buffer. It then writes the curdom CSR once, requests a pipeline flush, and acknowledges the commit only after the flush completes.
- Sits between the commit stage (request/ack), the CSR file (curdom write) and the controller (flush handshake).

Parameters:
- DomBits, 2, width of the domain identifier.
- NrDom, 4, number of legal domains; IDs >= NrDom are illegal.
- XLEN, 64, CSR write-data width.
- DrainTimeout, 255, DRAIN cycles after which drain_timeout_o is raised.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: synchronous, active-high.
- req_valid_i  in  1  commit port 0 holds a valid, exception-free chg_dom instruction.
- req_dom_i  in  DomBits  requested domain (data_dom).
- cur_dom_i  in  DomBits  current curdom CSR value.
- halt_i  in  1  core halt request.
- no_st_pending_i  in  1  store buffer empty.
- flush_done_i  in  1  controller finished the pipeline flush.
- req_ack_o  out  1  one-cycle commit acknowledge for the instruction.
- csr_write_dom_o  out  1  curdom CSR write strobe.
- csr_wdata_o  out  XLEN  zero-extended new domain; 0 when no write.
- flush_req_o  out  1  pipeline flush request (level).
- ex_valid_o  out  1  one-cycle illegal-domain exception pulse.
- ex_cause_o  out  XLEN  2 (illegal instruction) when ex_valid_o is high, else 0.
- busy_o  out  1  FSM not in IDLE.
- drain_timeout_o  out  1  sticky drain-timeout flag.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - state=IDLE; dom_q=0; drain counter=0; drain_timeout_o=0.
  - All outputs 0. Reset wins over every other event, including mid-sequence; no CSR write or ack is issued afterwards.
- All outputs are decoded from registered state/dom_q (Moore); no input-to-output combinational path.
- IDLE:
  - req_valid_i=1 and halt_i=0 and req_dom_i>=NrDom: ex_valid_o=1 and ex_cause_o=2 for one cycle (registered, next cycle); stay in IDLE; no ack.
  - Otherwise, if req_dom_i==cur_dom_i: go to ACK (no-op change).
  - Otherwise: latch dom_q=req_dom_i, clear the counter, go to DRAIN.
- DRAIN:
  - no_st_pending_i=1: go to WRITE.
  - Otherwise the counter increments, saturating at DrainTimeout. When it reaches DrainTimeout, drain_timeout_o is set and stays sticky until reset; waiting continues.
  - halt_i=1 or req_valid_i=0: abort to IDLE with no CSR write. Abort has priority over no_st_pending_i.
- WRITE:
  - csr_write_dom_o=1 and csr_wdata_o={zeros,dom_q} for exactly one cycle; go to FLUSH unconditionally.
  - Not abortable from this point onward; halt_i and req_valid_i are ignored until IDLE.
- FLUSH:
  - flush_req_o=1 in every FLUSH cycle.
  - flush_done_i=1: go to ACK. flush_done_i is ignored in all other states.
- ACK: req_ack_o=1 for one cycle; go to IDLE.
  - The IDLE cycle after ACK ignores req_valid_i, so the just-retired instruction is not re-accepted.
- busy_o=1 in DRAIN, WRITE, FLUSH and ACK.
- Latency, measured from the accepting IDLE edge with no_st_pending_i=1 and flush_done_i=1:
  - Different domain: WRITE at cycle +2, FLUSH at +3, req_ack_o at +4.
  - Same domain: req_ack_o at +1.
- Exactly one csr_write_dom_o pulse and one req_ack_o pulse per completed sequence; none on abort.
- Counter width is clog2(DrainTimeout+1); it never wraps.

Test Plan:
- Reset, then req_valid_i=1, req_dom_i=2, cur_dom_i=0, no_st_pending_i=1, flush_done_i tied 1 -> csr_write_dom_o at +2 with csr_wdata_o=2; flush_req_o at +3; req_ack_o at +4; busy_o high from +1 to +4.
- req_dom_i=1, cur_dom_i=1 -> req_ack_o at +1; no csr_write_dom_o and no flush_req_o.
- req_dom_i=3 with NrDom=3 -> ex_valid_o=1 and ex_cause_o=2 for one cycle; req_ack_o and busy_o stay 0.
- Different domain with no_st_pending_i=0 for 300 cycles, DrainTimeout=255 -> drain_timeout_o rises at the 255th DRAIN cycle and stays high; then no_st_pending_i=1 -> normal write/flush/ack; flag still 1 until rst_i.
- Assert halt_i during DRAIN -> return to IDLE with no write or ack. Assert halt_i or drop req_valid_i during FLUSH with flush_done_i delayed 10 cycles -> flush_req_o is held, then ack occurs.
- rst_i=1 in the FLUSH state -> next cycle all outputs 0 and state IDLE; no later ack.
